lsu_mem_ctrl: RTL and testbench

Memory-stage load/store controller. It takes the MEM-stage access request, drives a req/gnt/rvalid data bus, and stalls the pipeline until the access completes. It produces the lane-aligned, sign/zero-extended `load_data` that the MEM/WB pipeline register captures. It is the producer side of the MEM→WB load path: it turns raw bus read data into write-back-ready data.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_load_align.sv | 35 +++
 rtl/lsu_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the memory-stage load/store controller
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    // 2'b11 is reserved and handled as a word everywhere
    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    localparam int CNT_W = 16;

    // Half accesses need an even address, word (and reserved) accesses a word-aligned one
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - lane select and sign/zero extension of raw bus read data
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    mem_size_e   w_size;

    assign w_size = mem_size_e'(i_size);

    // Pick the addressed lane, then extend it to 32 bits
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (w_size)
            MEM_B:   o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            MEM_H:   o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - memory-stage load/store controller driving a req/gnt/rvalid bus
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_mem_i,
    input  logic        mem_re_mem_i,
    input  logic        mem_we_mem_i,
    input  logic [1:0]  mem_size_mem_i,
    input  logic        mem_unsigned_mem_i,
    input  logic [31:0] addr_mem_i,
    input  logic [31:0] wdata_mem_i,
    output logic        stall_o,
    output logic [31:0] load_data_mem_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_size;
    logic [1:0]       r_addr_lo;
    logic             r_unsigned;

    logic             w_access;
    logic             w_misaligned;
    logic             w_aligned_access;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_fmt;

    assign w_access         = instr_valid_mem_i & (mem_re_mem_i | mem_we_mem_i);
    assign w_misaligned     = is_misaligned(mem_size_mem_i, addr_mem_i[1:0]);
    assign w_aligned_access = w_access & ~w_misaligned;
    // >= so that a grant on the last counted cycle still times out in WAIT
    assign w_timeout        = (r_cnt >= LP_CNT_LAST);

    assign misaligned_o = (r_state == IDLE) & w_access & w_misaligned;
    assign stall_o      = ((r_state == IDLE) & w_aligned_access) | (r_state == REQ) | (r_state == WAIT);

    // Byte enables and lane-replicated store data for the presented access
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_mem_i;
        case (mem_size_e'(mem_size_mem_i))
            MEM_B: begin
                w_be    = 4'b0001 << addr_mem_i[1:0];
                w_wdata = {4{wdata_mem_i[7:0]}};
            end
            MEM_H: begin
                w_be    = 4'b0011 << {addr_mem_i[1], 1'b0};
                w_wdata = {2{wdata_mem_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata_mem_i;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .i_rdata    (bus_rdata_i),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_fmt)
    );

    // Access FSM with registered bus outputs, timeout counter and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_size          <= 2'b00;
            r_addr_lo       <= 2'b00;
            r_unsigned      <= 1'b0;
            bus_req_o       <= 1'b0;
            bus_we_o        <= 1'b0;
            bus_addr_o      <= '0;
            bus_be_o        <= '0;
            bus_wdata_o     <= '0;
            load_data_mem_o <= '0;
            bus_err_o       <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_aligned_access) begin
                        r_state     <= REQ;
                        r_cnt       <= '0;
                        r_size      <= mem_size_mem_i;
                        r_addr_lo   <= addr_mem_i[1:0];
                        r_unsigned  <= mem_unsigned_mem_i;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_mem_i;
                        bus_addr_o  <= {addr_mem_i[31:2], 2'b00};
                        bus_be_o    <= w_be;
                        bus_wdata_o <= w_wdata;
                    end
                end
                REQ: begin
                    if (bus_gnt_i && bus_rvalid_i) begin
                        r_state         <= DONE;
                        bus_req_o       <= 1'b0;
                        load_data_mem_o <= bus_we_o ? 32'h0 : w_load_fmt;
                    end else if (bus_gnt_i) begin
                        r_state   <= WAIT;
                        bus_req_o <= 1'b0;
                        r_cnt     <= r_cnt + 1'b1;
                    end else if (w_timeout) begin
                        r_state         <= DONE;
                        bus_req_o       <= 1'b0;
                        bus_err_o       <= 1'b1;
                        load_data_mem_o <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        r_state         <= DONE;
                        load_data_mem_o <= bus_we_o ? 32'h0 : w_load_fmt;
                    end else if (w_timeout) begin
                        r_state         <= DONE;
                        bus_err_o       <= 1'b1;
                        load_data_mem_o <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    logic        a_stall, a_mis, a_err, a_req, a_we;
    logic [31:0] a_load, a_addr, a_wdata;
    logic [3:0]  a_be;

    logic        t_stall, t_mis, t_err, t_req, t_we;
    logic [31:0] t_load, t_addr, t_wdata;
    logic [3:0]  t_be;

    int n_cmp  = 0;
    int n_fail = 0;
    int stall_cnt;
    int err_cnt;

    lsu_mem_ctrl u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instr_valid_mem_i  (instr_valid),
        .mem_re_mem_i       (re),
        .mem_we_mem_i       (we),
        .mem_size_mem_i     (size),
        .mem_unsigned_mem_i (uns),
        .addr_mem_i         (addr),
        .wdata_mem_i        (wdata),
        .stall_o            (a_stall),
        .load_data_mem_o    (a_load),
        .misaligned_o       (a_mis),
        .bus_err_o          (a_err),
        .bus_req_o          (a_req),
        .bus_we_o           (a_we),
        .bus_addr_o         (a_addr),
        .bus_be_o           (a_be),
        .bus_wdata_o        (a_wdata),
        .bus_gnt_i          (gnt),
        .bus_rvalid_i       (rvalid),
        .bus_rdata_i        (rdata)
    );

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(8)) u_dut_to (
        .clk                (clk),
        .rst_n              (rst_n),
        .instr_valid_mem_i  (instr_valid),
        .mem_re_mem_i       (re),
        .mem_we_mem_i       (we),
        .mem_size_mem_i     (size),
        .mem_unsigned_mem_i (uns),
        .addr_mem_i         (addr),
        .wdata_mem_i        (wdata),
        .stall_o            (t_stall),
        .load_data_mem_o    (t_load),
        .misaligned_o       (t_mis),
        .bus_err_o          (t_err),
        .bus_req_o          (t_req),
        .bus_we_o           (t_we),
        .bus_addr_o         (t_addr),
        .bus_be_o           (t_be),
        .bus_wdata_o        (t_wdata),
        .bus_gnt_i          (gnt),
        .bus_rvalid_i       (rvalid),
        .bus_rdata_i        (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        instr_valid = 1'b0;
        re          = 1'b0;
        we          = 1'b0;
        gnt         = 1'b0;
        rvalid      = 1'b0;
    endtask

    task automatic issue(input logic is_we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        instr_valid = 1'b1;
        re          = ~is_we;
        we          = is_we;
        size        = sz;
        uns         = u;
        addr        = a;
        wdata       = wd;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        size  = 2'b00;
        uns   = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        rdata = 32'h0;
        repeat (2) cyc();
        #1;
        chk("rst_req",    a_req,   0);
        chk("rst_we",     a_we,    0);
        chk("rst_addr",   a_addr,  32'h0);
        chk("rst_be",     a_be,    4'h0);
        chk("rst_wdata",  a_wdata, 32'h0);
        chk("rst_load",   a_load,  32'h0);
        chk("rst_err",    a_err,   0);
        chk("rst_stall",  a_stall, 0);
        chk("rst_mis",    a_mis,   0);
        rst_n = 1'b1;

        // LB 0x103, zero-wait bus
        cyc();
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        #1;
        stall_cnt = 32'(a_stall);
        chk("lb_idle_stall", a_stall, 1);
        cyc();
        chk("lb_req",  a_req,  1);
        chk("lb_addr", a_addr, 32'h0000_0100);
        chk("lb_be",   a_be,   4'b1000);
        chk("lb_we",   a_we,   0);
        stall_cnt += 32'(a_stall);
        gnt = 1'b1;
        cyc();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h80FF_1234;
        #1;
        chk("lb_wait_req", a_req, 0);
        stall_cnt += 32'(a_stall);
        cyc();
        rvalid = 1'b0;
        #1;
        chk("lb_load",       a_load,  32'hFFFF_FF80);
        chk("lb_done_stall", a_stall, 0);
        stall_cnt += 32'(a_stall);
        chk("lb_stall_cycles", stall_cnt, 3);
        idle_in();

        // LHU 0x102, grant and response together
        cyc();
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
        #1;
        chk("lhu_idle_stall", a_stall, 1);
        cyc();
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h8001_0000;
        #1;
        chk("lhu_be", a_be, 4'b1100);
        cyc();
        idle_in();
        #1;
        chk("lhu_load",  a_load,  32'h0000_8001);
        chk("lhu_stall", a_stall, 0);

        // SH 0x102
        cyc();
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_BEEF);
        #1;
        cyc();
        chk("sh_we",    a_we,    1);
        chk("sh_be",    a_be,    4'b1100);
        chk("sh_wdata", a_wdata, 32'hBEEF_BEEF);
        chk("sh_addr",  a_addr,  32'h0000_0100);
        gnt = 1'b1;
        cyc();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        cyc();
        rvalid = 1'b0;
        #1;
        chk("sh_load_zero", a_load, 32'h0);
        idle_in();

        // SB 0x001, grant and response together
        cyc();
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_56A5);
        #1;
        cyc();
        chk("sb_be",    a_be,    4'b0010);
        chk("sb_wdata", a_wdata, 32'hA5A5_A5A5);
        gnt    = 1'b1;
        rvalid = 1'b1;
        cyc();
        idle_in();

        // Misaligned accesses are flagged and never reach the bus
        cyc();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0202, 32'h1234_56A5);
        #1;
        chk("lw_mis",       a_mis,   1);
        chk("lw_mis_stall", a_stall, 0);
        chk("lw_mis_req",   a_req,   0);
        cyc();
        chk("lw_mis_req2",  a_req,   0);
        chk("lw_mis2",      a_mis,   1);
        size = 2'b01;
        addr = 32'h0000_0101;
        #1;
        chk("lh_mis", a_mis, 1);
        addr = 32'h0000_0102;
        #1;
        chk("lh_aligned_mis", a_mis, 0);
        idle_in();

        // LW 0x300, grant withheld 4 cycles, response 3 cycles after grant
        cyc();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h1234_56A5);
        #1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 4) gnt = 1'b1;
            #1;
            chk("slow_req",   a_req,   1);
            chk("slow_addr",  a_addr,  32'h0000_0300);
            chk("slow_be",    a_be,    4'b1111);
            chk("slow_stall", a_stall, 1);
        end
        for (int j = 0; j < 3; j++) begin
            cyc();
            gnt = 1'b0;
            if (j == 2) begin
                rvalid = 1'b1;
                rdata  = 32'hCAFE_F00D;
            end
            #1;
            chk("slow_wait_req",   a_req,   0);
            chk("slow_wait_stall", a_stall, 1);
        end
        cyc();
        rvalid = 1'b0;
        #1;
        chk("slow_done_stall", a_stall, 0);
        chk("slow_load",       a_load,  32'hCAFE_F00D);
        chk("slow_err",        a_err,   0);
        idle_in();

        // LB 0x010 with no grant: the TIMEOUT_CYCLES=8 instance aborts
        cyc();
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h1234_56A5);
        #1;
        err_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("to_req",   t_req,   1);
            chk("to_stall", t_stall, 1);
            err_cnt += 32'(t_err);
        end
        cyc();
        idle_in();
        #1;
        chk("to_err",       t_err,   1);
        chk("to_done_req",  t_req,   0);
        chk("to_load",      t_load,  32'h0);
        chk("to_done_stall", t_stall, 0);
        err_cnt += 32'(t_err);
        cyc();
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h1122_3344;
        #1;
        chk("to_idle_err",   t_err,   0);
        chk("to_idle_stall", t_stall, 0);
        err_cnt += 32'(t_err);
        cyc();
        idle_in();
        #1;
        chk("to_late_load",  t_load,  32'h0);
        chk("to_late_req",   t_req,   0);
        chk("to_late_stall", t_stall, 0);
        chk("to_err_pulses", err_cnt, 1);
        chk("long_req_load", a_load,  32'h0000_0044);
        chk("long_req_stall", a_stall, 0);

        // LW 0x400, reset asserted during WAIT
        cyc();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h1234_56A5);
        #1;
        cyc();
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        #1;
        chk("rw_wait_stall", a_stall, 1);
        rst_n = 1'b0;
        idle_in();
        #1;
        chk("rw_req",   a_req,   0);
        chk("rw_addr",  a_addr,  32'h0);
        chk("rw_be",    a_be,    4'h0);
        chk("rw_wdata", a_wdata, 32'h0);
        chk("rw_load",  a_load,  32'h0);
        chk("rw_stall", a_stall, 0);
        cyc();
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hFFFF_FFFF;
        cyc();
        rvalid = 1'b0;
        #1;
        chk("rw_late_load",  a_load,  32'h0);
        chk("rw_late_stall", a_stall, 0);
        chk("rw_late_req",   a_req,   0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h1234_56A5);
        #1;
        chk("rw_next_stall", a_stall, 1);
        cyc();
        gnt = 1'b1;
        #1;
        chk("rw_next_req",  a_req,  1);
        chk("rw_next_addr", a_addr, 32'h0000_0400);
        cyc();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h0BAD_F00D;
        cyc();
        rvalid = 1'b0;
        #1;
        chk("rw_next_load", a_load, 32'h0BAD_F00D);
        idle_in();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
